// File: rtl/bus_term_fifo.sv
// Per-terminal first-word-fall-through transmit FIFO feeding the bus arbiter.
// Presents its head word on D_pop with pndng and keeps sticky overflow/underflow flags.
module bus_term_fifo #(
  parameter int unsigned depth     = 16,
  parameter int unsigned ancho_pal = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         wr_en,
  input  logic [ancho_pal-1:0]         wr_data,
  output logic                         full,
  output logic                         pndng,
  output logic [ancho_pal-1:0]         D_pop,
  input  logic                         pop,
  output logic [$clog2(depth+1)-1:0]   count,
  output logic                         overflow,
  output logic                         underflow,
  input  logic                         clr_err
);

  localparam int unsigned PtrW = (depth > 1) ? $clog2(depth) : 1;
  localparam int unsigned CntW = $clog2(depth + 1);

  logic [ancho_pal-1:0] mem_q [depth];
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;
  logic                 empty, is_full;
  logic                 wr_ok, rd_ok;

  assign empty   = (count_q == '0);
  assign is_full = (count_q == CntW'(depth));

  // A pop frees the head slot in the same edge, so a full FIFO still takes a write.
  assign wr_ok = wr_en && (!is_full || pop);
  assign rd_ok = pop && !empty;

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_ok) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(depth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (rd_ok) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(depth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end

    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    // Setting an error takes priority over a same-cycle clear.
    if (wr_en && is_full && !pop) overflow_d  = 1'b1;
    if (pop && empty)             underflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign count     = count_q;
  assign pndng     = !empty;
  assign full      = is_full;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign D_pop     = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_bus_term_fifo.sv
// Scoreboard bench for bus_term_fifo: a queue model tracks accepted packets and
// is compared against D_pop on every accepted pop, plus flag/occupancy checks each cycle.
module tb_bus_term_fifo;

  localparam int unsigned Depth = 16;
  localparam int unsigned Width = 32;

  logic             clk;
  logic             reset;
  logic             wr_en;
  logic [Width-1:0] wr_data;
  logic             full;
  logic             pndng;
  logic [Width-1:0] D_pop;
  logic             pop;
  logic [4:0]       count;
  logic             overflow;
  logic             underflow;
  logic             clr_err;

  bus_term_fifo #(
    .depth     (Depth),
    .ancho_pal (Width)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .pndng     (pndng),
    .D_pop     (D_pop),
    .pop       (pop),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow),
    .clr_err   (clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [Width-1:0] sb_q [$];
  logic             ovf_m;
  logic             unf_m;
  int               n_checks;
  int               n_pass;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [31:0] head;
    head = (sb_q.size() != 0) ? sb_q[0] : 32'h0;
    check_eq({tag, "_count"}, 32'(count), 32'(sb_q.size()));
    check_eq({tag, "_pndng"}, 32'(pndng), 32'(sb_q.size() != 0));
    check_eq({tag, "_full"},  32'(full),  32'(sb_q.size() == Depth));
    check_eq({tag, "_dpop"},  D_pop, head);
    check_eq({tag, "_ovf"},   32'(overflow),  32'(ovf_m));
    check_eq({tag, "_unf"},   32'(underflow), 32'(unf_m));
  endtask

  // Called at a negedge: drive one cycle, update the model at the edge, check afterwards.
  task automatic cycle(input string tag, input logic w, input logic [Width-1:0] d,
                       input logic p, input logic c);
    bit full_m, empty_m;
    wr_en   = w;
    wr_data = d;
    pop     = p;
    clr_err = c;
    #1;
    full_m  = (sb_q.size() == Depth);
    empty_m = (sb_q.size() == 0);
    if (p && !empty_m) check_eq({tag, "_popdata"}, D_pop, sb_q[0]);
    @(posedge clk);
    if (c) begin
      ovf_m = 1'b0;
      unf_m = 1'b0;
    end
    if (w && full_m && !p) ovf_m = 1'b1;
    if (p && empty_m)      unf_m = 1'b1;
    if (p && !empty_m) void'(sb_q.pop_front());
    if (w && (!full_m || p)) sb_q.push_back(d);
    @(negedge clk);
    wr_en   = 1'b0;
    pop     = 1'b0;
    clr_err = 1'b0;
    check_state(tag);
  endtask

  // Writes and pops are held active during reset to show they are ignored.
  task automatic do_reset(input int n);
    reset   = 1'b0;
    wr_en   = 1'b1;
    wr_data = 32'hDEAD_BEEF;
    pop     = 1'b1;
    clr_err = 1'b0;
    repeat (n) @(posedge clk);
    sb_q.delete();
    ovf_m = 1'b0;
    unf_m = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    wr_en = 1'b0;
    pop   = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    ovf_m    = 1'b0;
    unf_m    = 1'b0;
    wr_data  = '0;

    // 1. reset then idle
    do_reset(2);
    check_state("rst");
    cycle("idle", 1'b0, '0, 1'b0, 1'b0);

    // 2. single packet, FWFT head, pop two edges later
    cycle("t2_wr", 1'b1, 32'h0200_ABCD, 1'b0, 1'b0);
    check_eq("t2_head", D_pop, 32'h0200_ABCD);
    cycle("t2_idle", 1'b0, '0, 1'b0, 1'b0);
    cycle("t2_pop", 1'b0, '0, 1'b1, 1'b0);
    check_eq("t2_empty", 32'(pndng), 32'h0);

    // 3. fill, overflow, drain in order
    for (int i = 0; i < 17; i++) begin
      cycle("t3_wr", 1'b1, 32'(i), 1'b0, 1'b0);
      if (i == 15) check_eq("t3_full", 32'(full), 32'h1);
      if (i == 15) check_eq("t3_noovf", 32'(overflow), 32'h0);
    end
    check_eq("t3_ovf", 32'(overflow), 32'h1);
    for (int i = 0; i < 16; i++) begin
      check_eq("t3_order", D_pop, 32'(i));
      cycle("t3_pop", 1'b0, '0, 1'b1, 1'b0);
    end
    check_eq("t3_drained", 32'(count), 32'h0);

    // 4. simultaneous write+pop while full
    cycle("t4_clr", 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) cycle("t4_fill", 1'b1, 32'(100 + i), 1'b0, 1'b0);
    cycle("t4_wp", 1'b1, 32'hFF00_0001, 1'b1, 1'b0);
    check_eq("t4_cnt", 32'(count), 32'd16);
    check_eq("t4_head", D_pop, 32'd101);
    check_eq("t4_ovf", 32'(overflow), 32'h0);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check_eq("t4_last", D_pop, 32'hFF00_0001);
      cycle("t4_pop", 1'b0, '0, 1'b1, 1'b0);
    end

    // 5. empty corners and clear/set priority
    cycle("t5_pope", 1'b0, '0, 1'b1, 1'b0);
    check_eq("t5_unf", 32'(underflow), 32'h1);
    cycle("t5_wpe", 1'b1, 32'h0300_1234, 1'b1, 1'b0);
    check_eq("t5_cnt", 32'(count), 32'h1);
    check_eq("t5_head", D_pop, 32'h0300_1234);
    cycle("t5_clr", 1'b0, '0, 1'b0, 1'b1);
    check_eq("t5_unfclr", 32'(underflow), 32'h0);
    cycle("t5_pop", 1'b0, '0, 1'b1, 1'b0);
    cycle("t5_setwin", 1'b0, '0, 1'b1, 1'b1);
    check_eq("t5_setwin_unf", 32'(underflow), 32'h1);
    cycle("t5_clr2", 1'b0, '0, 1'b0, 1'b1);

    // 6. random mix through pointer wrap, then reset with data in flight
    for (int i = 0; i < 40; i++) begin
      cycle("t6_rand", 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0);
    end
    while (sb_q.size() > 5) cycle("t6_trim", 1'b0, '0, 1'b1, 1'b0);
    while (sb_q.size() < 5) cycle("t6_top", 1'b1, $urandom, 1'b0, 1'b0);
    check_eq("t6_cnt5", 32'(count), 32'd5);
    do_reset(1);
    check_state("t6_rst");
    check_eq("t6_rstcnt", 32'(count), 32'h0);
    cycle("t6_stale", 1'b0, '0, 1'b1, 1'b0);
    check_eq("t6_nostale", D_pop, 32'h0);
    cycle("t6_wr", 1'b1, 32'h0400_5678, 1'b0, 1'b0);
    cycle("t6_pop", 1'b0, '0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
